// File: rtl/cache_axi_burst_bridge.sv
//==============================================================================
// cache_axi_burst_bridge: cache line refill / write-back <-> AXI INCR bursts. Rev 1.0
//==============================================================================
`default_nettype none

module cache_axi_burst_bridge #(
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [31:0]              rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic [32*LINE_WORDS-1:0] ret_data,
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    output logic                     wr_valid,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic                     rvalid,
    input  logic                     rlast,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int            CW   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_RET = 2'd3} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_B = 2'd3} wr_state_t;

    rd_state_t                 rstate_q;
    logic [31:0]               araddr_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic [CW-1:0]             rcnt_q;
    logic [32*LINE_WORDS-1:0]  ret_data_q;
    logic                      ret_valid_q;

    wr_state_t                 wstate_q;
    logic [31:0]               awaddr_q;
    logic [32*LINE_WORDS-1:0]  wline_q;
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic                      bready_q;
    logic [CW-1:0]             wcnt_q;
    logic                      wr_valid_q;

    logic                      haz;
    logic                      unused_ok;

    assign unused_ok = &{1'b0, rlast, rd_addr[3:0], wr_addr[3:0]};

    // A refill of the line currently being written back would fetch stale data.
    assign haz    = (wstate_q != W_IDLE) && (rd_addr[31:4] == awaddr_q[31:4]);
    assign rd_rdy = (rstate_q == R_IDLE) && !haz;
    assign wr_rdy = (wstate_q == W_IDLE);

    assign arid      = AXI_ID;
    assign araddr    = araddr_q;
    assign arlen     = 8'(LINE_WORDS - 1);
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ret_valid = ret_valid_q;
    assign ret_data  = ret_data_q;

    assign awid      = AXI_ID;
    assign awaddr    = awaddr_q;
    assign awlen     = 8'(LINE_WORDS - 1);
    assign awsize    = 3'b010;
    assign awburst   = 2'b01;
    assign awvalid   = awvalid_q;
    assign wstrb     = 4'hF;
    assign wvalid    = wvalid_q;
    assign wlast     = (wstate_q == W_DATA) && (wcnt_q == LAST);
    assign bready    = bready_q;
    assign wr_valid  = wr_valid_q;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (wcnt_q == CW'(i)) wdata = wline_q[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q    <= R_IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rcnt_q      <= '0;
            ret_data_q  <= '0;
            ret_valid_q <= 1'b0;
        end else begin
            ret_valid_q <= 1'b0;
            case (rstate_q)
                R_IDLE: if (rd_req && rd_rdy) begin
                    araddr_q  <= {rd_addr[31:4], 4'b0000};
                    arvalid_q <= 1'b1;
                    rstate_q  <= R_AR;
                end
                R_AR: if (arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    rstate_q  <= R_DATA;
                end
                R_DATA: if (rvalid) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        if (rcnt_q == CW'(i)) ret_data_q[i*32 +: 32] <= rdata;
                    end
                    // Beat count, not rlast, closes the burst.
                    if (rcnt_q == LAST) begin
                        rcnt_q      <= '0;
                        rready_q    <= 1'b0;
                        ret_valid_q <= 1'b1;
                        rstate_q    <= R_RET;
                    end else begin
                        rcnt_q <= rcnt_q + ONE;
                    end
                end
                R_RET:   rstate_q <= R_IDLE;
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            awaddr_q   <= '0;
            wline_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wcnt_q     <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            case (wstate_q)
                W_IDLE: if (wr_req) begin
                    awaddr_q  <= {wr_addr[31:4], 4'b0000};
                    wline_q   <= wr_data;
                    awvalid_q <= 1'b1;
                    wstate_q  <= W_AW;
                end
                W_AW: if (awready) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    wstate_q  <= W_DATA;
                end
                W_DATA: if (wready) begin
                    if (wcnt_q == LAST) begin
                        wcnt_q   <= '0;
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        wstate_q <= W_B;
                    end else begin
                        wcnt_q <= wcnt_q + ONE;
                    end
                end
                W_B: if (bvalid) begin
                    bready_q   <= 1'b0;
                    wr_valid_q <= 1'b1;
                    wstate_q   <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_axi_burst_bridge.sv
//==============================================================================
// tb_cache_axi_burst_bridge: scoreboard bench with AXI slave models. Rev 1.0
//==============================================================================
`default_nettype none

module tb_cache_axi_burst_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req, rd_rdy, ret_valid, wr_req, wr_rdy, wr_valid;
    logic [31:0]  rd_addr, wr_addr;
    logic [127:0] ret_data, wr_data;
    logic [3:0]   arid, awid, wstrb;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready, rvalid, rlast, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    cache_axi_burst_bridge #(.LINE_WORDS(4), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_valid(wr_valid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [127:0] data;
        int           lat;
    } ret_t;

    logic [31:0] q_ar[$];
    ret_t        q_ret[$];
    logic [31:0] q_aw[$];
    logic [32:0] q_w[$];
    int          q_wrv[$];

    int checks = 0;
    int errors = 0;

    int          ar_stall = 0;
    bit          r_gaps   = 1'b0;
    bit          w_toggle = 1'b0;
    int          b_delay  = 0;
    logic [31:0] rd_beats [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read-side slave: AR acceptance after ar_stall cycles, beats with optional gaps.
    bit hs_ar, hs_r, r_active;
    int r_beat, ar_cnt, gapc;
    initial begin
        arready = 0; rvalid = 0; rlast = 0; rdata = 0;
        r_active = 0; r_beat = 0; ar_cnt = 0; gapc = 0;
        forever begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            @(posedge clk); #1;
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; r_active = 0; r_beat = 0; ar_cnt = 0;
            end else begin
                if (hs_ar) begin
                    arready = 0; r_active = 1; r_beat = 0; ar_cnt = 0;
                end else if (arvalid && !r_active) begin
                    if (ar_cnt >= ar_stall) arready = 1;
                    else ar_cnt++;
                end
                if (hs_r) begin
                    r_beat++;
                    if (r_beat == 4) r_active = 0;
                end
                rvalid = 0; rlast = 0;
                if (r_active) begin
                    gapc++;
                    if (!(r_gaps && (gapc % 3 == 1))) begin
                        rvalid = 1;
                        rdata  = rd_beats[r_beat];
                        rlast  = (r_beat == 3);
                    end
                end
            end
        end
    end

    // Write-side slave: immediate AW, optionally toggling wready, B after b_delay.
    bit hs_aw, hs_w, w_l, hs_b, b_pend;
    int b_cnt;
    initial begin
        awready = 0; wready = 0; bvalid = 0; b_pend = 0; b_cnt = 0;
        forever begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            w_l   = wlast;
            hs_b  = bvalid && bready;
            @(posedge clk); #1;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; b_pend = 0;
            end else begin
                awready = awvalid;
                if (hs_w && w_l) begin b_pend = 1; b_cnt = 0; end
                if (hs_b) bvalid = 0;
                if (b_pend) begin
                    if (b_cnt >= b_delay) begin bvalid = 1; b_pend = 0; end
                    else b_cnt++;
                end
                wready = w_toggle ? (wvalid ? ~wready : 1'b0) : 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or pulse.
    int          cyc = 0, acc_cyc = 0;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wlast, p_ret, p_hsb;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [31:0] e32;
    logic [32:0] e33;
    ret_t        er;
    initial begin
        {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wlast, p_ret, p_hsb} = '0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wlast, p_ret, p_hsb} = '0;
                continue;
            end
            if (rd_req && rd_rdy) acc_cyc = cyc;
            if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   chk("w_hold", {wvalid, wdata, wlast}, {1'b1, p_wdata, p_wlast});
            if (awvalid) chk("w_before_aw", wvalid, 1'b0);
            if (arvalid && arready) begin
                chk("ar_expected", q_ar.size() != 0, 1'b1);
                if (q_ar.size() != 0) begin
                    e32 = q_ar.pop_front();
                    chk("ar", {arid, araddr, arlen, arsize, arburst}, {4'd0, e32, 8'd3, 3'd2, 2'd1});
                end
            end
            if (awvalid && awready) begin
                chk("aw_expected", q_aw.size() != 0, 1'b1);
                if (q_aw.size() != 0) begin
                    e32 = q_aw.pop_front();
                    chk("aw", {awid, awaddr, awlen, awsize, awburst}, {4'd0, e32, 8'd3, 3'd2, 2'd1});
                end
            end
            if (wvalid && wready) begin
                chk("w_expected", q_w.size() != 0, 1'b1);
                if (q_w.size() != 0) begin
                    e33 = q_w.pop_front();
                    chk("w_beat", {wdata, wlast, wstrb}, {e33, 4'hF});
                end
            end
            if (ret_valid) begin
                chk("ret_single_pulse", p_ret, 1'b0);
                chk("ret_expected", q_ret.size() != 0, 1'b1);
                if (q_ret.size() != 0) begin
                    er = q_ret.pop_front();
                    chk("ret_data", ret_data, er.data);
                    // Latency counted inclusively from the accept cycle.
                    if (er.lat > 0) chk("ret_latency", cyc - acc_cyc + 1, er.lat);
                end
            end
            if (wr_valid) begin
                chk("wr_valid_after_b", p_hsb, 1'b1);
                chk("wr_valid_expected", q_wrv.size() != 0, 1'b1);
                if (q_wrv.size() != 0) void'(q_wrv.pop_front());
            end
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
            p_ret = ret_valid; p_hsb = bvalid && bready;
        end
    end

    task automatic expect_read(input logic [31:0] exp_araddr, input logic [127:0] line,
                               input int lat, input bit exp_ret);
        ret_t t;
        for (int i = 0; i < 4; i++) rd_beats[i] = line[i*32 +: 32];
        q_ar.push_back(exp_araddr);
        if (exp_ret) begin
            t.data = line;
            t.lat  = lat;
            q_ret.push_back(t);
        end
    endtask

    task automatic expect_write(input logic [31:0] exp_awaddr, input logic [127:0] line);
        q_aw.push_back(exp_awaddr);
        for (int i = 0; i < 4; i++) q_w.push_back({line[i*32 +: 32], i == 3});
        q_wrv.push_back(1);
    endtask

    task automatic start_read(input logic [31:0] addr);
        bit got;
        got = 0;
        @(posedge clk); #1;
        rd_req = 1; rd_addr = addr;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rd_rdy) begin got = 1; break; end
        end
        chk("rd_accept", got, 1'b1);
        @(posedge clk); #1;
        rd_req = 0;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [127:0] line);
        bit got;
        got = 0;
        @(posedge clk); #1;
        wr_req = 1; wr_addr = addr; wr_data = line;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr_rdy) begin got = 1; break; end
        end
        chk("wr_accept", got, 1'b1);
        @(posedge clk); #1;
        wr_req = 0;
    endtask

    task automatic wait_evt(input string name, input bit wr);
        bit got;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (wr ? wr_valid : ret_valid) begin got = 1; break; end
        end
        chk(name, got, 1'b1);
    endtask

    localparam logic [127:0] L_A = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] L_W = 128'hD3D30003_D2D20002_D1D10001_D0D00000;
    localparam logic [127:0] L_H = 128'h5A5A0004_5A5A0003_5A5A0002_5A5A0001;
    localparam logic [127:0] L_C = 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001;
    localparam logic [127:0] L_F = 128'hF00D0004_F00D0003_F00D0002_F00D0001;

    initial begin
        int n;
        rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {rd_rdy, wr_rdy, arvalid, rready, awvalid, wvalid, bready, ret_valid, wr_valid},
            9'b110000000);
        chk("reset_ret_data", ret_data, 128'd0);
        @(posedge clk); #3 rst = 0;

        // Minimum-latency refill.
        expect_read(32'h1000_0010, L_A, 7, 1);
        start_read(32'h1000_0014);
        wait_evt("read_fast_done", 0);

        // Same refill with AR stall and R gaps.
        ar_stall = 5; r_gaps = 1;
        expect_read(32'h1000_0010, L_A, 0, 1);
        start_read(32'h1000_0014);
        wait_evt("read_slow_done", 0);
        ar_stall = 0; r_gaps = 0;

        // Write-back with toggling wready.
        w_toggle = 1;
        expect_write(32'h2000_0020, L_W);
        start_write(32'h2000_002C, L_W);
        wait_evt("write_done", 1);
        w_toggle = 0;

        // Same-line read blocked until the write-back completes.
        b_delay = 12;
        expect_write(32'h2000_0020, L_H);
        start_write(32'h2000_0020, L_W ^ L_H ^ L_W);
        expect_read(32'h2000_0020, L_A ^ L_H, 7, 1);
        rd_req = 1; rd_addr = 32'h2000_0028;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr_valid) begin
                chk("hazard_release", rd_rdy, 1'b1);
                n = 1;
                break;
            end
            chk("hazard_block", rd_rdy, 1'b0);
        end
        chk("hazard_wr_valid_seen", n, 1);
        @(posedge clk); #1;
        rd_req = 0;
        wait_evt("hazard_read_done", 0);

        // Different-line read and write issued together, running concurrently.
        b_delay = 10;
        expect_write(32'h2000_0020, L_C);
        expect_read(32'h3000_0000, L_F, 7, 1);
        @(posedge clk); #1;
        rd_req = 1; rd_addr = 32'h3000_0000;
        wr_req = 1; wr_addr = 32'h2000_0020; wr_data = L_C;
        @(negedge clk);
        chk("simultaneous_accept", {rd_rdy, wr_rdy}, 2'b11);
        @(posedge clk); #1;
        rd_req = 0; wr_req = 0;
        wait_evt("concurrent_read_done", 0);
        chk("concurrent_write_busy", wr_rdy, 1'b0);
        wait_evt("concurrent_write_done", 1);
        b_delay = 0;

        // Reset after two beats: partial line dropped, no pulse.
        expect_read(32'h1000_0040, L_F, 0, 0);
        start_read(32'h1000_0048);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rvalid && rready) n++;
            if (n == 2) break;
        end
        chk("mid_reset_two_beats", n, 2);
        @(posedge clk); #2 rst = 1;
        @(negedge clk);
        chk("mid_reset_ctrl", {rready, rd_rdy, ret_valid, arvalid, wr_rdy}, 5'b01001);
        chk("mid_reset_ret_data", ret_data, 128'd0);
        @(posedge clk); #3 rst = 0;

        // Fresh refill after reset.
        expect_read(32'h1000_0080, L_C, 7, 1);
        start_read(32'h1000_0084);
        wait_evt("post_reset_read_done", 0);

        repeat (5) @(negedge clk);
        chk("q_ar_empty", q_ar.size(), 0);
        chk("q_ret_empty", q_ret.size(), 0);
        chk("q_aw_empty", q_aw.size(), 0);
        chk("q_w_empty", q_w.size(), 0);
        chk("q_wrv_empty", q_wrv.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
